// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state encoding.
package mmio_uart_tx_pkg;

  localparam logic [7:0] UART_TXDATA_OFF = 8'h00;
  localparam logic [7:0] UART_STATUS_OFF = 8'h04;
  localparam logic [7:0] UART_BAUD_OFF   = 8'h08;

  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_EMPTY_BIT  = 2;
  localparam int STAT_OVF_BIT    = 3;
  localparam int STAT_CNT_LSB    = 4;
  localparam int STAT_PARITY_BIT = 31;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Word index of a byte address; the two low address bits never select anything.
  function automatic logic [5:0] reg_index(input logic [7:0] addr);
    return addr[7:2];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// MMIO responder port of the UART transmitter: core drives the request,
// the UART returns combinational read data.
interface mmio_uart_tx_if;
  logic        i_mmio_enable;
  logic [7:0]  i_mmio_addr;
  logic        i_mmio_wen;
  logic [31:0] i_mmio_data_in;
  logic [31:0] o_mmio_data_out;

  modport master (
    output i_mmio_enable, i_mmio_addr, i_mmio_wen, i_mmio_data_in,
    input  o_mmio_data_out
  );

  modport slave (
    input  i_mmio_enable, i_mmio_addr, i_mmio_wen, i_mmio_data_in,
    output o_mmio_data_out
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted
// only when a pop happens in the same cycle.
module mmio_uart_tx_sync_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DWIDTH-1:0]        din_i,
  output logic [DWIDTH-1:0]        dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable divisor.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frame).
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 150000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_WIDTH   = 16
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  mmio,
  output logic           o_uart_tx
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(CLK_FREQ_HZ / BAUD_RATE - 1);

  uart_tx_state_t     state_q, state_d;
  logic [DIV_WIDTH-1:0] baud_div_q, baud_div_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         data_q, data_d;
  logic               ovf_q, ovf_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]         fifo_dout;
  logic [CNT_W-1:0]   fifo_count;

  logic               wr_en, bit_end, tx;
  logic [5:0]         reg_sel;
  logic [31:0]        rdata;
  logic               unused_ok;

  assign wr_en     = mmio.i_mmio_enable && mmio.i_mmio_wen;
  assign reg_sel   = reg_index(mmio.i_mmio_addr);
  assign fifo_push = wr_en && (reg_sel == reg_index(UART_TXDATA_OFF));
  assign bit_end   = (bit_cnt_q == div_q);
  assign unused_ok = ^{mmio.i_mmio_addr[1:0], mmio.i_mmio_data_in};

  mmio_uart_tx_sync_fifo #(
    .DWIDTH (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (mmio.i_mmio_data_in[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    baud_div_d = baud_div_q;
    ovf_d      = ovf_q;
    if (wr_en && (reg_sel == reg_index(UART_BAUD_OFF)))
      baud_div_d = mmio.i_mmio_data_in[DIV_WIDTH-1:0];
    if (fifo_push && fifo_full && !fifo_pop)
      ovf_d = 1'b1;
    else if (wr_en && (reg_sel == reg_index(UART_STATUS_OFF)) && mmio.i_mmio_data_in[STAT_OVF_BIT])
      ovf_d = 1'b0;
  end

  // Frame sequencer: the divisor is captured whenever a byte is popped,
  // so divisor writes only take effect at the next frame boundary.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + DIV_WIDTH'(1);
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    div_d     = div_q;
    fifo_pop  = 1'b0;
    tx        = 1'b1;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_dout;
          div_d    = baud_div_q;
          state_d  = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx = data_q[bit_idx_q];
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = ^data_q;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_dout;
            div_d    = baud_div_q;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_div_q <= DIV_RESET;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_div_q <= baud_div_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q    <= data_d;
    div_q     <= div_d;
    bit_cnt_q <= bit_cnt_d;
    bit_idx_q <= bit_idx_d;
  end

  always_comb begin
    rdata = '0;
    if (!reset && mmio.i_mmio_enable) begin
      if (reg_sel == reg_index(UART_STATUS_OFF)) begin
        rdata[STAT_BUSY_BIT]             = (state_q != IDLE);
        rdata[STAT_FULL_BIT]             = fifo_full;
        rdata[STAT_EMPTY_BIT]            = fifo_empty;
        rdata[STAT_OVF_BIT]              = ovf_q;
        rdata[STAT_CNT_LSB +: CNT_W]     = fifo_count;
`ifdef UART_TX_PARITY_EN
        rdata[STAT_PARITY_BIT]           = 1'b1;
`endif
      end else if (reg_sel == reg_index(UART_BAUD_OFF)) begin
        rdata[DIV_WIDTH-1:0] = baud_div_q;
      end
    end
  end

  assign mmio.o_mmio_data_out = rdata;
  assign o_uart_tx            = tx;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. It is a responder on the core's MMIO port and sits beside the board GPIO map behind the memory map decoder's MMIO enable.
- The core writes bytes into a TX FIFO. A baud-rate FSM serialises them onto a single output pin, 8N1 framing.
- The core polls STATUS and reprograms the baud divisor through MMIO registers.
- Read data is combinational; the top level registers it by one cycle to match BRAM latency.

Parameters:
- CLK_FREQ_HZ, 150000000, main clock frequency.
- BAUD_RATE, 115200, reset baud rate.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
- DIV_WIDTH, 16, width of the baud divisor register.

Ports:
- clk  in  1  main clock.
- reset  in  1  synchronous, active-high reset.
- i_mmio_enable  in  1  MMIO region selected this cycle.
- i_mmio_addr  in  8  byte address; bits [7:2] select the register, bits [1:0] are ignored.
- i_mmio_wen  in  1  full-word write strobe.
- i_mmio_data_in  in  32  write data.
- o_mmio_data_out  out  32  read data, combinational from address and registered state.
- o_uart_tx  out  1  serial line; idles high.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - o_uart_tx = 1.
  - FIFO empty; FSM in IDLE.
  - overflow flag = 0.
  - baud_div = CLK_FREQ_HZ/BAUD_RATE - 1 (1301 at the defaults).
  - o_mmio_data_out = 0 while reset is asserted.
- Register map (word offsets):
  - 0x00 TXDATA: write pushes i_mmio_data_in[7:0]; reads as 0.
  - 0x04 STATUS: read gives bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow, bits[4+log2(FIFO_DEPTH):4] count, all other bits 0. Writing with bit3 = 1 clears overflow; all other write bits are ignored.
  - 0x08 BAUD_DIV: read/write; the low DIV_WIDTH bits are used and upper read bits are 0.
  - Any other offset reads 0; writes to it are ignored.
- Gating:
  - Writes take effect only when i_mmio_enable = 1 and i_mmio_wen = 1.
  - With i_mmio_enable = 0, o_mmio_data_out = 0.
- FIFO:
  - Synchronous, first-word-fall-through.
  - A push while full is dropped and sets overflow, unless a pop happens in the same cycle; in that case the push is accepted and count is unchanged.
  - Count stays in the range 0 to FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- Bit timing:
  - Each bit lasts baud_div + 1 cycles. The bit counter runs 0 to baud_div.
  - baud_div = 0 is legal and gives 1 cycle per bit.
  - baud_div is latched at frame start, so a write mid-frame affects only the next frame.
- FSM:
  - IDLE: o_uart_tx = 1. If the FIFO is non-empty, pop the head into the shift register, latch the divisor, and go to START.
  - START: o_uart_tx = 0 for one bit time, then go to DATA.
  - DATA: send 8 bits LSB first; a 3-bit index counts 0 to 7, then go to PARITY if enabled, otherwise STOP.
  - PARITY: one bit time (only when the optional feature is enabled), then go to STOP.
  - STOP: o_uart_tx = 1 for one bit time. At its last cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Latency: a TXDATA write in cycle N with the FIFO empty and the FSM in IDLE drives o_uart_tx low from cycle N+2.
- Reset mid-frame: the next cycle has o_uart_tx = 1, the FIFO is flushed, and the partial frame is lost.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state sends the even-parity bit (XOR of the 8 data bits) between DATA and STOP, giving an 11-bit frame. STATUS bit 31 reads 1.
- Undefined: 10-bit 8N1 frame, no PARITY state, STATUS bit 31 reads 0.

Decomposition:
- Shared package riscv_pkg gains:
  - register offset constants UART_TXDATA_OFF = 0x00, UART_STATUS_OFF = 0x04, UART_BAUD_OFF = 0x08;
  - typedef enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - STATUS bit-position constants.
- One sub-module: sync_fifo, parameterised by DWIDTH and DEPTH, with push, pop, dout, full, empty and count outputs.

Test Plan:
- Reset default divisor: after reset, read 0x04 -> 0x00000004 (empty = 1); read 0x08 -> 1301.
- Single frame: write 0x08 = 3, then TXDATA = 0xA5 in cycle N -> o_uart_tx low from N+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high. Busy reads 1 throughout and 0 at N+42.
- Back-to-back: push 0x55 then 0xAA -> the second start bit immediately follows the first stop bit with no idle cycle; empty is set after the second pop.
- Overflow: with baud_div = 1000, push 18 bytes -> the first is popped into the shift register, 16 fill the FIFO, the 18th is dropped. STATUS reads full = 1, overflow = 1, count = 16. Writing 0x08 to STATUS clears overflow.
- Mid-frame divisor change: write 0x08 = 7 during a frame sent at divisor 3 -> the current frame keeps 4 cycles per bit; the next frame uses 8.
- Reset mid-frame: assert reset during DATA -> o_uart_tx = 1 on the next cycle, STATUS reads 0x00000004, and no further edges appear on o_uart_tx. With UART_TX_PARITY_EN defined, 0xA5 gives parity bit 0 and 0x01 gives parity bit 1.
